// File: rtl/fog_sync_demod_if.sv
// Bus for the PIG FOG synchronous demodulator: per-period configuration, ADC stream
// and the error/strobe pair that feeds the downstream moving-average filter.
interface fog_sync_demod_if #(
    parameter int ADC_W = 14
);
    logic                    i_en;
    logic signed [ADC_W-1:0] i_adc_data;
    logic [15:0]             i_freq_cnt;
    logic [15:0]             i_wait_cnt;
    logic                    i_polarity;
    logic [4:0]              i_gain_shift;
    logic signed [31:0]      i_err_offset;
    logic                    o_mod_stat;
    logic signed [31:0]      o_err;
    logic                    o_strobe;

    modport master (
        output i_en, i_adc_data, i_freq_cnt, i_wait_cnt,
               i_polarity, i_gain_shift, i_err_offset,
        input  o_mod_stat, o_err, o_strobe
    );

    modport slave (
        input  i_en, i_adc_data, i_freq_cnt, i_wait_cnt,
               i_polarity, i_gain_shift, i_err_offset,
        output o_mod_stat, o_err, o_strobe
    );
endinterface

// File: rtl/fog_sync_demod.sv
// Square-wave synchronous demodulator: integrates ADC samples per half-period and emits
// one scaled high/low difference per period. Define FOG_DEMOD_SAT_EN to saturate o_err.
module fog_sync_demod #(
    parameter int ADC_W = 14,
    parameter int ACC_W = 48
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fog_sync_demod_if.slave bus
);
    localparam int DIFF_W  = ACC_W + 1;
    localparam int SHIFT_W = ACC_W + 33;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [15:0]              r_cnt;
    logic [15:0]              r_h;
    logic [15:0]              r_w;
    logic                     r_pol;
    logic [4:0]               r_shift;
    logic signed [31:0]       r_offset;
    logic signed [ACC_W-1:0]  r_accHigh;
    logic signed [ACC_W-1:0]  r_accLow;
    logic signed [31:0]       r_err;
    logic                     r_strobe;

    logic                     w_lastCnt;
    logic                     w_sampleEn;
    logic                     w_periodEnd;
    logic                     w_latchCfg;
    logic signed [ACC_W-1:0]  w_sampleExt;
    logic signed [ACC_W-1:0]  w_accLowFinal;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [DIFF_W-1:0] w_diffPol;
    logic signed [SHIFT_W-1:0] w_shifted;
    logic signed [SHIFT_W-1:0] w_final;
    logic signed [31:0]       w_errNext;

    assign w_lastCnt     = (r_cnt == (r_h - 16'd1));
    assign w_sampleEn    = (r_cnt >= r_w);
    assign w_sampleExt   = {{(ACC_W-ADC_W){bus.i_adc_data[ADC_W-1]}}, bus.i_adc_data};

    // The final low-half sample is folded in combinationally so the error is ready at period end.
    assign w_accLowFinal = r_accLow + (w_sampleEn ? w_sampleExt : '0);
    assign w_diff        = {r_accHigh[ACC_W-1], r_accHigh} - {w_accLowFinal[ACC_W-1], w_accLowFinal};
    assign w_diffPol     = r_pol ? -w_diff : w_diff;
    assign w_shifted     = {{(SHIFT_W-DIFF_W){w_diffPol[DIFF_W-1]}}, w_diffPol} << r_shift;
    assign w_final       = w_shifted - {{(SHIFT_W-32){r_offset[31]}}, r_offset};

`ifdef FOG_DEMOD_SAT_EN
    always_comb begin
        w_errNext = w_final[31:0];
        if (!((&w_final[SHIFT_W-1:31]) || !(|w_final[SHIFT_W-1:31]))) begin
            w_errNext = w_final[SHIFT_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
    end
`else
    logic w_unusedUpper;
    assign w_unusedUpper = ^w_final[SHIFT_W-1:32];
    always_comb begin
        w_errNext = w_final[31:0];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_periodEnd = 1'b0;
        w_latchCfg  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_en) begin
                    w_nextState = S_HIGH;
                    w_latchCfg  = 1'b1;
                end
            end
            S_HIGH: begin
                if (!bus.i_en) begin
                    w_nextState = S_IDLE;
                end else if (w_lastCnt) begin
                    w_nextState = S_LOW;
                end
            end
            S_LOW: begin
                if (!bus.i_en) begin
                    w_nextState = S_IDLE;
                end else if (w_lastCnt) begin
                    w_nextState = S_HIGH;
                    w_periodEnd = 1'b1;
                    w_latchCfg  = 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_h       <= '0;
            r_w       <= '0;
            r_pol     <= 1'b0;
            r_shift   <= '0;
            r_offset  <= '0;
            r_accHigh <= '0;
            r_accLow  <= '0;
            r_err     <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_latchCfg) begin
                r_h      <= (bus.i_freq_cnt < 16'd2) ? 16'd2 : bus.i_freq_cnt;
                r_w      <= bus.i_wait_cnt;
                r_pol    <= bus.i_polarity;
                r_shift  <= bus.i_gain_shift;
                r_offset <= bus.i_err_offset;
            end
            if (w_periodEnd) begin
                r_err    <= w_errNext;
                r_strobe <= 1'b1;
            end
            // Leaving a running period, for any reason, starts the next one from empty sums.
            if ((w_nextState == S_IDLE) || w_periodEnd) begin
                r_cnt     <= '0;
                r_accHigh <= '0;
                r_accLow  <= '0;
            end else if (r_state == S_HIGH) begin
                if (w_sampleEn) begin
                    r_accHigh <= r_accHigh + w_sampleExt;
                end
                r_cnt <= w_lastCnt ? 16'd0 : (r_cnt + 16'd1);
            end else if (r_state == S_LOW) begin
                r_accLow <= w_accLowFinal;
                r_cnt    <= r_cnt + 16'd1;
            end
        end
    end

    assign bus.o_mod_stat = (r_state == S_HIGH);
    assign bus.o_err      = r_err;
    assign bus.o_strobe   = r_strobe;
endmodule

// File: tb/tb_fog_sync_demod.sv
// Randomized bench for fog_sync_demod: a period-level model sums the samples by their
// position in each period and predicts o_err, o_strobe and o_mod_stat every clock.
module tb_fog_sync_demod;
    localparam int ADC_W = 14;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    fog_sync_demod_if #(.ADC_W(ADC_W)) bus ();

    fog_sync_demod #(.ADC_W(ADC_W), .ACC_W(48)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int freqCnt = 4;
    int waitCnt = 1;
    bit polarity = 1'b0;
    int gainShift = 0;
    int errOffset = 0;

    bit mRun = 1'b0;
    int mPos = 0;
    int mH = 2;
    int mW = 0;
    bit mPol = 1'b0;
    int mShift = 0;
    int mOffset = 0;
    int mSamples[$];
    int expErr = 0;
    bit expStrobe = 1'b0;
    bit expMod = 1'b0;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int computeErr();
        longint hi = 0;
        longint lo = 0;
        logic signed [127:0] v;
        for (int p = 0; p < 2 * mH; p++) begin
            if (p < mH) begin
                if (p >= mW) hi += mSamples[p];
            end else begin
                if (p - mH >= mW) lo += mSamples[p];
            end
        end
        v = hi;
        v = v - lo;
        if (mPol) v = -v;
        v = v <<< mShift;
        v = v - mOffset;
`ifdef FOG_DEMOD_SAT_EN
        if (v > 128'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -128'sd2147483648) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    task automatic latchConfig();
        mH      = (bus.i_freq_cnt < 16'd2) ? 2 : int'(bus.i_freq_cnt);
        mW      = int'(bus.i_wait_cnt);
        mPol    = bus.i_polarity;
        mShift  = int'(bus.i_gain_shift);
        mOffset = bus.i_err_offset;
    endtask

    task automatic modelEdge();
        expStrobe = 1'b0;
        if (!bus.i_en) begin
            mRun = 1'b0;
            mSamples.delete();
        end else if (!mRun) begin
            latchConfig();
            mRun = 1'b1;
            mPos = 0;
            mSamples.delete();
        end else begin
            mSamples.push_back(int'(bus.i_adc_data));
            mPos++;
            if (mPos == 2 * mH) begin
                expErr = computeErr();
                expStrobe = 1'b1;
                latchConfig();
                mPos = 0;
                mSamples.delete();
            end
        end
        expMod = mRun && (mPos < mH);
    endtask

    task automatic applyStimulus(input bit en, input int adc);
        @(negedge clk);
        bus.i_en         = en;
        bus.i_adc_data   = adc[ADC_W-1:0];
        bus.i_freq_cnt   = freqCnt[15:0];
        bus.i_wait_cnt   = waitCnt[15:0];
        bus.i_polarity   = polarity;
        bus.i_gain_shift = gainShift[4:0];
        bus.i_err_offset = errOffset;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("strobe", bus.o_strobe, expStrobe);
        checkOutput("mod_stat", bus.o_mod_stat, expMod);
        checkOutput("err", bus.o_err, expErr);
    endtask

    task automatic runPattern(input string tag, input int f, input int w, input bit pol,
                              input int sh, input int off, input int adcHi, input int adcLo,
                              input int cycles, input int constErr);
        freqCnt = f; waitCnt = w; polarity = pol; gainShift = sh; errOffset = off;
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, bus.o_mod_stat ? adcHi : adcLo);
            if (bus.o_strobe) checkOutput(tag, bus.o_err, constErr);
        end
    endtask

    initial begin
        int strobeAt[$];
        bus.i_en = 1'b0; bus.i_adc_data = '0; bus.i_freq_cnt = 16'd4; bus.i_wait_cnt = 16'd1;
        bus.i_polarity = 1'b0; bus.i_gain_shift = '0; bus.i_err_offset = '0;
        #1;
        checkOutput("reset_err", bus.o_err, 0);
        checkOutput("reset_strobe", bus.o_strobe, 0);
        checkOutput("reset_mod", bus.o_mod_stat, 0);
        #20;
        @(negedge clk);
        rstN = 1'b1;

        runPattern("basic", 4, 1, 1'b0, 0, 0, 100, 20, 26, 240);
        runPattern("pol_off", 4, 1, 1'b1, 0, 40, 100, 20, 26, -280);
        runPattern("shift_off", 4, 1, 1'b0, 1, 40, 100, 20, 26, 440);
        runPattern("wait_ge_h", 4, 5, 1'b0, 0, 7, 100, 20, 26, -7);
        runPattern("h_clamp", 0, 0, 1'b0, 0, 0, 10, 3, 14, 14);
`ifdef FOG_DEMOD_SAT_EN
        runPattern("sat_pos", 4, 0, 1'b0, 16, 0, 8191, -8192, 18, 32'h7FFF_FFFF);
        runPattern("sat_neg", 4, 0, 1'b1, 16, 0, 8191, -8192, 18, 32'h8000_0000);
`else
        runPattern("wrap_pos", 4, 0, 1'b0, 16, 0, 8191, -8192, 18, -262144);
        runPattern("wrap_neg", 4, 0, 1'b1, 16, 0, 8191, -8192, 18, 262144);
`endif

        freqCnt = 4; waitCnt = 0; polarity = 1'b0; gainShift = 0; errOffset = 0;
        applyStimulus(1'b0, 0);
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) freqCnt = 8;
            applyStimulus(1'b1, $urandom_range(0, 16383) - 8192);
            if (bus.o_strobe) strobeAt.push_back(i);
        end
        checkOutput("fchg_count", strobeAt.size(), 2);
        if (strobeAt.size() >= 2) begin
            checkOutput("fchg_first", strobeAt[0], 9);
            checkOutput("fchg_second", strobeAt[1], 25);
        end

        freqCnt = 4;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom_range(0, 16383) - 8192);
        applyStimulus(1'b0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 50);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1234);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        bus.i_en = 1'b0;
        #1;
        checkOutput("async_err", bus.o_err, 0);
        checkOutput("async_strobe", bus.o_strobe, 0);
        checkOutput("async_mod", bus.o_mod_stat, 0);
        mRun = 1'b0; mSamples.delete(); expErr = 0; expStrobe = 1'b0; expMod = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        strobeAt.delete();
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 16383) - 8192);
            if (bus.o_strobe) strobeAt.push_back(i);
        end
        checkOutput("rst_restart_count", strobeAt.size(), 1);
        if (strobeAt.size() >= 1) checkOutput("rst_restart_first", strobeAt[0], 9);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                freqCnt = $urandom_range(0, 9);
                waitCnt = $urandom_range(0, 10);
            end
            polarity  = $urandom_range(0, 1);
            gainShift = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
            errOffset = int'($urandom) >>> $urandom_range(0, 31);
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 16383) - 8192);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fog_sync_demod.md
Name: fog_sync_demod

Overview:
- Synchronous demodulator for the PIG FOG loop, directly upstream of the power-of-two moving-average filter.
- Generates the square-wave modulation status and accumulates ADC samples separately in the high and low half-periods, skipping a settling window at the start of each half.
- Once per modulation period, emits a signed 32-bit error sample with a one-cycle strobe.
- o_err drives the filter's i_data; o_strobe drives its i_update_strobe.

Parameters:
- ADC_W, 14: signed ADC sample width.
- ACC_W, 48: signed half-period accumulator width.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  demodulation enable.
- i_adc_data  in  ADC_W  signed ADC sample, sampled every clock.
- i_freq_cnt  in  16  half-period length H in clocks.
- i_wait_cnt  in  16  settling skip W in clocks at the start of each half.
- i_polarity  in  1  0: err = high - low; 1: err = low - high.
- i_gain_shift  in  5  left shift applied to the difference, 0..31.
- i_err_offset  in  32  signed offset subtracted after the shift.
- o_mod_stat  out  1  1 during the high half, 0 during the low half and idle.
- o_err  out  32  signed demodulated error; holds its value between updates.
- o_strobe  out  1  one-cycle pulse when o_err is updated.

Behaviour:
- Clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values: o_err=0, o_strobe=0, o_mod_stat=0, accumulators=0, cnt=0, state=S_IDLE.
- State S_IDLE:
  - o_mod_stat=0, accumulators and cnt held at 0, no strobes.
  - With i_en=1 at a clock edge: latch config, go to S_HIGH with cnt=0.
- Config latch: H, W, polarity, shift and offset are captured only on entry to S_HIGH (period start). Changes mid-period take effect at the next period.
- H clamp: latched H = max(i_freq_cnt, 2).
- State S_HIGH:
  - o_mod_stat=1.
  - Each clock: if cnt >= W then acc_h += sign-extended i_adc_data.
  - cnt==H-1: go to S_LOW, cnt=0; otherwise cnt++.
- State S_LOW:
  - o_mod_stat=0; same rule, accumulating into acc_l.
  - On cnt==H-1 the current sample is included, then:
    - d = acc_h - acc_l, in ACC_W+1 bits.
    - Negate d if polarity=1.
    - Left-shift d by the latched shift in ACC_W+33 bits.
    - Subtract the sign-extended offset.
    - Convert to 32 bits (see Optional Feature) and register into o_err.
  - Same edge: clear both accumulators, set cnt=0, re-latch config, go to S_HIGH.
- Timing:
  - o_strobe=1 on the cycle after the last low-half sample, with o_err already valid.
  - Period is exactly 2H clocks.
  - Strobes are never back-to-back.
- W >= H: no samples are accumulated, so d=0 and o_err = -offset.
- i_en deasserted in any state: next edge goes to S_IDLE, discarding the partial period. No strobe is issued; o_err holds its last value.
- Re-enable always starts a fresh high half.
- Reset asserted mid-period: all state and outputs immediately return to reset values.

Optional Feature:
- Macro: FOG_DEMOD_SAT_EN.
- Defined: the final value is saturated to [-2147483648, 2147483647].
- Undefined: the low 32 bits are taken (two's-complement wrap).

Test Plan:
- H=4, W=1, shift=0, offset=0, pol=0, adc=100 in the high half and 20 in the low half -> o_err=240 (300-60), o_strobe every 8 clocks, o_mod_stat 4 high / 4 low; first strobe 9 clocks after S_HIGH entry.
- Same as above with pol=1 and offset=40 -> o_err=-280; with pol=0, offset=40 and shift=1 -> o_err=440.
- H=65535, W=0, adc=8191 high / -8192 low:
  - shift=1 -> o_err=2147319810.
  - shift=2 with FOG_DEMOD_SAT_EN -> 2147483647.
  - shift=2 without it -> -327676.
- W=5, H=4 -> o_err = -offset, e.g. offset=7 gives -7; i_freq_cnt=0 behaves as H=2 (strobe every 4 clocks).
- Change i_freq_cnt from 4 to 8 mid-high-half -> the current period completes at 8 clocks and the next is 16; drop i_en mid-period -> no strobe, o_err holds, o_mod_stat=0.
- Assert i_rst_n=0 asynchronously mid-low-half -> o_err, o_strobe, o_mod_stat go to 0 immediately; after release with i_en=1, the first strobe arrives exactly 2H+1 clocks after S_HIGH entry.
